// File: rtl/cm85_cascade_seq.sv
// Sequencer that reuses one external 4-bit cascade magnitude-comparator slice
// to compare two WIDTH-bit unsigned operands, one nibble per cycle, LSB first.
module cm85_cascade_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       sl_a,
  output logic [3:0]       sl_b,
  output logic             sl_lt_i,
  output logic             sl_eq_i,
  output logic             sl_gt_i,
  input  logic             sl_lt_o,
  input  logic             sl_eq_o,
  input  logic             sl_gt_o,
  output logic             sl_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_err
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [2:0]    CASC_EQ  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
  logic [2:0]       acc_r, acc_s;
  logic             err_r, err_s;
  logic [2:0]       slice_s;
  logic [WIDTH-1:0] a_sh_s, b_sh_s;
  logic             run_s, done_s;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  assign slice_s = {sl_lt_o, sl_eq_o, sl_gt_o};
  assign run_s   = (state_r == RUN);
  assign done_s  = (state_r == DONE);

  // Current nibble selected by shifting the captured operand down by 4*idx.
  assign a_sh_s = a_r >> {idx_r, 2'b00};
  assign b_sh_s = b_r >> {idx_r, 2'b00};

  assign sl_en                       = run_s;
  assign sl_a                        = run_s ? a_sh_s[3:0] : 4'h0;
  assign sl_b                        = run_s ? b_sh_s[3:0] : 4'h0;
  assign {sl_lt_i, sl_eq_i, sl_gt_i} = run_s ? acc_r : CASC_EQ;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = done_s;
  assign out_lt    = done_s & acc_r[2];
  assign out_eq    = done_s & acc_r[1];
  assign out_gt    = done_s & acc_r[0];
  assign out_err   = done_s & err_r;

  // Next-state: capture in IDLE, fold slice results in RUN, hold in DONE.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    a_s     = a_r;
    b_s     = b_r;
    acc_s   = acc_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s     = in_a;
          b_s     = in_b;
          idx_s   = {IW{1'b0}};
          acc_s   = CASC_EQ;
          err_s   = 1'b0;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // A malformed triple is kept as-is; it only taints the error flag.
        acc_s = slice_s;
        err_s = err_r | ~onehot3(slice_s);
        if (idx_r == IDX_LAST) begin
          state_s = DONE;
        end else begin
          idx_s = idx_r + IDX_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= CASC_EQ;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      a_r     <= a_s;
      b_r     <= b_s;
      acc_r   <= acc_s;
      err_r   <= err_s;
    end
  end

endmodule

// File: tb/tb_cm85_cascade_seq.sv
// Directed + randomized bench for cm85_cascade_seq with a behavioural slice
// model and an arithmetic reference for per-nibble cascade and final result.
module tb_cm85_cascade_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic             sl_lt_i, sl_eq_i, sl_gt_i;
  logic             sl_lt_o, sl_eq_o, sl_gt_o;
  logic             sl_en;
  logic             out_valid;
  logic             out_ready;
  logic             out_lt, out_eq, out_gt, out_err;

  int n_vec;
  int n_err;
  int cur_nib;
  int bad_nib;

  cm85_cascade_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .sl_a      (sl_a),
    .sl_b      (sl_b),
    .sl_lt_i   (sl_lt_i),
    .sl_eq_i   (sl_eq_i),
    .sl_gt_i   (sl_gt_i),
    .sl_lt_o   (sl_lt_o),
    .sl_eq_o   (sl_eq_o),
    .sl_gt_o   (sl_gt_o),
    .sl_en     (sl_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lt    (out_lt),
    .out_eq    (out_eq),
    .out_gt    (out_gt),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External comparator slice, with an optional forced-bad nibble.
  always_comb begin
    if (bad_nib >= 0 && bad_nib == cur_nib)
      {sl_lt_o, sl_eq_o, sl_gt_o} = 3'b011;
    else if (sl_a > sl_b)
      {sl_lt_o, sl_eq_o, sl_gt_o} = 3'b001;
    else if (sl_a < sl_b)
      {sl_lt_o, sl_eq_o, sl_gt_o} = 3'b100;
    else
      {sl_lt_o, sl_eq_o, sl_gt_o} = {sl_lt_i, sl_eq_i, sl_gt_i};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a < b) return 3'b100;
    else if (a > b) return 3'b001;
    else return 3'b010;
  endfunction

  // Cascade entering nibble k is the comparison of the low 4*k bits.
  function automatic logic [2:0] exp_casc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k);
    logic [WIDTH-1:0] m;
    if (k == 0) return 3'b010;
    m = {WIDTH{1'b1}} >> (WIDTH - 4 * k);
    return cmp3(a & m, b & m);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_outs"}, {28'd0, out_lt, out_eq, out_gt, out_err}, 32'd0);
    chk({tag, "_sl_en"}, {31'd0, sl_en}, 32'd0);
    chk({tag, "_sl_ab"}, {24'd0, sl_a, sl_b}, 32'd0);
    chk({tag, "_casc"}, {29'd0, sl_lt_i, sl_eq_i, sl_gt_i}, 32'd2);
  endtask

  task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
  endtask

  // Checks n RUN cycles; on return sits at the negedge of the last checked cycle.
  task automatic run_nibs(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      cur_nib = k;
      #1;
      chk("run_sl_en", {31'd0, sl_en}, 32'd1);
      chk("run_in_ready", {31'd0, in_ready}, 32'd0);
      chk("run_sl_a", {28'd0, sl_a}, {28'd0, 4'((a >> (4 * k)) & 'hF)});
      chk("run_sl_b", {28'd0, sl_b}, {28'd0, 4'((b >> (4 * k)) & 'hF)});
      if (bad_nib < 0 || k <= bad_nib)
        chk("run_casc", {29'd0, sl_lt_i, sl_eq_i, sl_gt_i}, {29'd0, exp_casc(a, b, k)});
      chk("run_no_valid", {31'd0, out_valid}, 32'd0);
    end
  endtask

  task automatic compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    accept(a, b);
    run_nibs(a, b, NIB);
    @(negedge clk);
    cur_nib = -1;
    chk("done_valid", {31'd0, out_valid}, 32'd1);
    chk("done_result", {29'd0, out_lt, out_eq, out_gt}, {29'd0, cmp3(a, b)});
    chk("done_err", {31'd0, out_err}, {31'd0, (bad_nib >= 0)});
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    chk("done_sl_en", {31'd0, sl_en}, 32'd0);
  endtask

  task automatic release_to_idle();
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("post");
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    n_vec = 0; n_err = 0; cur_nib = -1; bad_nib = -1;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #2;
    chk_idle("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("after_reset");

    // Equal operands: single-cycle out_valid, 4 cycles after accept.
    compare(16'h1234, 16'h1234);
    release_to_idle();
    // MSB nibble overrides lower gt cascade.
    compare(16'h0FFF, 16'h1000);
    release_to_idle();
    // gt in nibble 0 propagates through equal upper nibbles.
    compare(16'h1235, 16'h1234);
    release_to_idle();

    // Held result with new operands presented in DONE.
    out_ready = 1'b0;
    compare(16'hA5A5, 16'h5A5A);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_result", {29'd0, out_lt, out_eq, out_gt}, 32'd1);
    end
    in_valid = 1'b0;
    release_to_idle();
    compare(16'h0010, 16'h0100);
    release_to_idle();

    // Reset mid-RUN at idx=2.
    accept(16'hFFFF, 16'h0000);
    run_nibs(16'hFFFF, 16'h0000, 3);
    rst_n = 1'b0;
    cur_nib = -1;
    #1;
    chk_idle("midreset");
    @(negedge clk);
    chk_idle("midreset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("midreset_rel");
    compare(16'h0001, 16'h0002);
    release_to_idle();

    // Malformed slice triple on nibble 1, then a clean compare.
    bad_nib = 1;
    compare(16'h5000, 16'h1000);
    bad_nib = -1;
    release_to_idle();
    compare(16'h7777, 16'h7777);
    release_to_idle();

    // Randomized compares, biased toward equal and near-equal operands.
    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      case (i % 3)
        0: rb = ra;
        1: rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1, 0));
        default: rb = WIDTH'($urandom);
      endcase
      out_ready = ($urandom_range(1, 0) == 1);
      compare(ra, rb);
      release_to_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
